// File: rtl/programmable_clock_division.sv
// Multi-channel runtime-programmable clock divider with duty control, period-start
// tick, shadowed divisor updates applied at period boundaries, and a global phase sync.
module programmable_clock_division #(
  parameter int CHANNELS    = 2,
  parameter int WIDTH       = 8,
  parameter int DEFAULT_DIV = 2
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [CHANNELS-1:0]       enable,
  input  logic [CHANNELS-1:0]       load,
  input  logic [CHANNELS*WIDTH-1:0] div_value,
  input  logic [CHANNELS*WIDTH-1:0] high_value,
  input  logic                      sync,
  output logic [CHANNELS-1:0]       new_clock,
  output logic [CHANNELS-1:0]       tick,
  output logic [CHANNELS-1:0]       pending
);

  localparam logic [WIDTH-1:0] DIV_RST  = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] HIGH_RST = WIDTH'(DEFAULT_DIV / 2);

  // A period shorter than two cycles cannot produce both a high and a low phase.
  function automatic logic [WIDTH-1:0] clamp_div(input logic [WIDTH-1:0] d);
    return (d < WIDTH'(2)) ? WIDTH'(2) : d;
  endfunction

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_div_act;
    logic [WIDTH-1:0] r_high_act;
    logic [WIDTH-1:0] r_div_sh;
    logic [WIDTH-1:0] r_high_sh;
    logic             r_pend;
    logic             r_clk;
    logic             r_tick;

    logic [WIDTH-1:0] w_div_sh_nxt;
    logic [WIDTH-1:0] w_high_sh_nxt;
    logic             w_pend_nxt;
    logic             w_wrap;
    logic             w_boundary;

    // A load in the same cycle as a boundary is applied at that boundary.
    assign w_div_sh_nxt  = load[i] ? clamp_div(div_value[i*WIDTH +: WIDTH]) : r_div_sh;
    assign w_high_sh_nxt = load[i] ? high_value[i*WIDTH +: WIDTH] : r_high_sh;
    assign w_pend_nxt    = load[i] | r_pend;
    assign w_wrap        = (r_cnt == (r_div_act - WIDTH'(1)));
    assign w_boundary    = !enable[i] || sync || w_wrap;

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        r_cnt      <= '0;
        r_div_act  <= DIV_RST;
        r_high_act <= HIGH_RST;
        r_div_sh   <= DIV_RST;
        r_high_sh  <= HIGH_RST;
        r_pend     <= 1'b0;
        r_clk      <= 1'b0;
        r_tick     <= 1'b0;
      end else begin
        r_div_sh  <= w_div_sh_nxt;
        r_high_sh <= w_high_sh_nxt;
        if (!enable[i]) begin
          r_cnt  <= '0;
          r_clk  <= 1'b0;
          r_tick <= 1'b0;
        end else begin
          r_clk  <= (r_cnt < r_high_act);
          r_tick <= (r_cnt == '0);
          r_cnt  <= (sync || w_wrap) ? '0 : r_cnt + WIDTH'(1);
        end
        if (w_boundary) begin
          if (w_pend_nxt) begin
            r_div_act  <= w_div_sh_nxt;
            r_high_act <= w_high_sh_nxt;
          end
          r_pend <= 1'b0;
        end else begin
          r_pend <= w_pend_nxt;
        end
      end
    end

    assign new_clock[i] = r_clk;
    assign tick[i]      = r_tick;
    assign pending[i]   = r_pend;
  end

endmodule

// File: tb/tb_programmable_clock_division.sv
// Directed bench for programmable_clock_division: reset, waveform shape, runtime
// reprogramming, divisor/duty edge cases, sync alignment and asynchronous reset.
module tb_programmable_clock_division;

  localparam int CH = 2;
  localparam int W  = 8;

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic [CH-1:0]   enable = '0;
  logic [CH-1:0]   load = '0;
  logic [CH*W-1:0] div_value = '0;
  logic [CH*W-1:0] high_value = '0;
  logic            sync = 1'b0;
  logic [CH-1:0]   new_clock;
  logic [CH-1:0]   tick;
  logic [CH-1:0]   pending;

  int checks = 0;
  int errors = 0;

  programmable_clock_division #(.CHANNELS(CH), .WIDTH(W), .DEFAULT_DIV(2)) dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .load       (load),
    .div_value  (div_value),
    .high_value (high_value),
    .sync       (sync),
    .new_clock  (new_clock),
    .tick       (tick),
    .pending    (pending)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Load channel 0 while it is disabled (applies at once), then enable it.
  task automatic prog0(input logic [W-1:0] d, input logic [W-1:0] h);
    enable[0] = 1'b0;
    load[0] = 1'b1;
    div_value[W-1:0] = d;
    high_value[W-1:0] = h;
    step();
    load[0] = 1'b0;
    check("prog_pending_cleared", 32'(pending[0]), 32'd0);
    enable[0] = 1'b1;
  endtask

  task automatic run0(input string tag, input int d, input int h, input int n);
    for (int k = 0; k < n; k++) begin
      step();
      check({tag, "_clk"},  32'(new_clock[0]), 32'((k % d) < h));
      check({tag, "_tick"}, 32'(tick[0]),      32'((k % d) == 0));
    end
  endtask

  initial begin
    // Reset held with all channels enabled
    reset = 1'b0;
    enable = 2'b11;
    for (int k = 0; k < 3; k++) begin
      step();
      check("rst_clk",  32'(new_clock), 32'd0);
      check("rst_tick", 32'(tick),      32'd0);
      check("rst_pend", 32'(pending),   32'd0);
    end
    reset = 1'b1;
    step(); check("dflt_clk_e1", 32'(new_clock), 32'h3); check("dflt_tick_e1", 32'(tick), 32'h3);
    step(); check("dflt_clk_e2", 32'(new_clock), 32'h0); check("dflt_tick_e2", 32'(tick), 32'h0);
    step(); check("dflt_clk_e3", 32'(new_clock), 32'h3); check("dflt_tick_e3", 32'(tick), 32'h3);
    step(); check("dflt_clk_e4", 32'(new_clock), 32'h0); check("dflt_tick_e4", 32'(tick), 32'h0);
    enable = 2'b00;
    step();
    check("disable_clk", 32'(new_clock), 32'd0);

    // div=5 high=2 -> 1,1,0,0,0 with tick on the first high cycle
    prog0(8'd5, 8'd2);
    run0("wave5", 5, 2, 10);

    // Edge cases
    prog0(8'd0, 8'd1);
    run0("div0", 2, 1, 4);
    prog0(8'd4, 8'd0);
    run0("high0", 4, 0, 8);
    prog0(8'd8, 8'd9);
    run0("high9", 8, 9, 9);
    check("ch1_idle", 32'(new_clock[1]), 32'd0);

    // Runtime change: div=4 high=2, load div=6 high=3 while counter=1
    prog0(8'd4, 8'd2);
    step(); check("rt_e1_clk", 32'(new_clock[0]), 32'd1); check("rt_e1_tick", 32'(tick[0]), 32'd1);
    load[0] = 1'b1;
    div_value[W-1:0] = 8'd6;
    high_value[W-1:0] = 8'd3;
    step(); load[0] = 1'b0;
    check("rt_e2_clk", 32'(new_clock[0]), 32'd1); check("rt_e2_pend", 32'(pending[0]), 32'd1);
    step(); check("rt_e3_clk", 32'(new_clock[0]), 32'd0); check("rt_e3_pend", 32'(pending[0]), 32'd1);
    step(); check("rt_e4_clk", 32'(new_clock[0]), 32'd0); check("rt_e4_pend", 32'(pending[0]), 32'd0);
    check("rt_e4_tick", 32'(tick[0]), 32'd0);
    run0("rt_new", 6, 3, 7);

    // Sync: both channels div=3 high=1, channel 1 started one cycle later
    enable = 2'b00;
    load = 2'b11;
    div_value = {8'd3, 8'd3};
    high_value = {8'd1, 8'd1};
    step();
    load = 2'b00;
    enable = 2'b01;
    step(); check("sy_a_tick", 32'(tick), 32'h1);
    enable = 2'b11;
    step(); check("sy_b_tick", 32'(tick), 32'h2);
    step(); check("sy_c_tick", 32'(tick), 32'h0);
    step(); check("sy_d_tick", 32'(tick), 32'h1);
    sync = 1'b1;
    step(); sync = 1'b0;
    check("sy_e_tick", 32'(tick), 32'h2);
    for (int k = 0; k < 6; k++) begin
      step();
      check("sy_al_tick", 32'(tick),      (k % 3 == 0) ? 32'h3 : 32'h0);
      check("sy_al_clk",  32'(new_clock), (k % 3 == 0) ? 32'h3 : 32'h0);
    end
    enable = 2'b01;
    for (int k = 0; k < 3; k++) begin
      step();
      check("sy_dis_clk1",  32'(new_clock[1]), 32'd0);
      check("sy_dis_tick1", 32'(tick[1]),      32'd0);
    end
    enable = 2'b00;

    // Asynchronous reset between edges at counter=2 with a load pending
    prog0(8'd5, 8'd4);
    step();
    step(); check("ar_pre_clk", 32'(new_clock[0]), 32'd1);
    load[0] = 1'b1;
    div_value[W-1:0] = 8'd7;
    high_value[W-1:0] = 8'd1;
    step(); load[0] = 1'b0;
    check("ar_pre_pend", 32'(pending[0]), 32'd1);
    check("ar_pre_clk2", 32'(new_clock[0]), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("ar_clk_async",  32'(new_clock), 32'd0);
    check("ar_pend_async", 32'(pending),   32'd0);
    check("ar_tick_async", 32'(tick),      32'd0);
    step();
    reset = 1'b1;
    run0("ar_dflt", 2, 1, 6);
    check("ar_pend_after", 32'(pending[0]), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
